// File: rtl/avalon_chk_pkg.sv
// Shared definitions for the Avalon-MM checker: bus-mode encoding, error-bit
// indices and the write-burst tracking FSM states.
package avalon_chk_pkg;

  typedef enum logic [2:0] {
    MODE_WAITREQ    = 3'd0,
    MODE_FIXED      = 3'd1,
    MODE_PIPE_VAR   = 3'd2,
    MODE_PIPE_FIXED = 3'd3,
    MODE_BURST      = 3'd4
  } mode_e;

  localparam int unsigned ERR_RW_CONFLICT  = 0;
  localparam int unsigned ERR_UNSTABLE     = 1;
  localparam int unsigned ERR_SPURIOUS_RDV = 2;
  localparam int unsigned ERR_PENDING_OVF  = 3;
  localparam int unsigned ERR_LATENCY      = 4;
  localparam int unsigned ERR_BURST_LEN    = 5;
  localparam int unsigned ERR_BURST_ABORT  = 6;
  localparam int unsigned ERR_TIMEOUT      = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    WBURST = 1'b1
  } wburst_state_t;

  // True when the integer mode parameter selects the given bus mode.
  function automatic bit mode_is(int unsigned mode, mode_e m);
    return mode == 32'(m);
  endfunction

endpackage

// File: rtl/avalon_chk_latency_pipe.sv
// Shift register of depth DEPTH; tap is the bit shifted in DEPTH edges earlier.
// Used to predict readdatavalid for fixed-latency pipelined reads.
module avalon_chk_latency_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_in,
  output logic tap
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  // Next pipe contents: shift towards the tap, new bit enters at index 0.
  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = shift_in;
  end

  // Pipe register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_q <= '0;
    else      pipe_q <= pipe_d;
  end

  assign tap = pipe_q[DEPTH-1];

endmodule

// File: rtl/avalon_mm_checker.sv
// Avalon-MM protocol checker for all five bus modes. Flags violations as a
// registered per-cycle pulse vector plus sticky flags, and tracks outstanding
// read beats and remaining write-burst beats.
// Optional: define AVALON_CHK_STATS_EN to add rd_cnt/wr_cnt/rdv_cnt counters.
module avalon_mm_checker #(
  parameter int unsigned AVALONMODE   = 0,
  parameter int unsigned NBDATABYTES  = 2,
  parameter int unsigned NBADDRBITS   = 8,
  parameter int unsigned FIXEDWAIT    = 2,
  parameter int unsigned FIXEDREADLAT = 1,
  parameter int unsigned MAXPENDING   = 8,
  parameter int unsigned MAXBURST     = 16,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NBADDRBITS-1:0]                      address,
  input  logic [NBDATABYTES-1:0]                     byteenable,
  input  logic                                       read,
  input  logic                                       write,
  input  logic                                       waitrequest,
  input  logic                                       readdatavalid,
  input  logic [7:0]                                 burstcount,
  input  logic                                       beginbursttransfer,
  input  logic                                       clr_err,
  output logic [7:0]                                 err_pulse,
  output logic [7:0]                                 err_sticky,
  output logic [$clog2(MAXPENDING*MAXBURST+1)-1:0]   pending,
`ifdef AVALON_CHK_STATS_EN
  output logic [31:0]                                rd_cnt,
  output logic [31:0]                                wr_cnt,
  output logic [31:0]                                rdv_cnt,
`endif
  output logic [7:0]                                 burst_left
);
  import avalon_chk_pkg::*;

  localparam int unsigned PendW   = $clog2(MAXPENDING * MAXBURST + 1);
  localparam int unsigned PendMax = MAXPENDING * MAXBURST;
  localparam int unsigned SumW    = PendW + 9;
  localparam int unsigned StallW  = $clog2(TIMEOUT + 1);
  localparam int unsigned HoldW   = $clog2(FIXEDWAIT + 1);

  localparam bit IsFixedWait  = mode_is(AVALONMODE, MODE_FIXED);
  localparam bit IsPipeFixed  = mode_is(AVALONMODE, MODE_PIPE_FIXED);
  localparam bit IsBurst      = mode_is(AVALONMODE, MODE_BURST);
  localparam bit WaitHonoured = !IsFixedWait && !IsPipeFixed;
  localparam bit TracksPend   = AVALONMODE >= 32'(MODE_PIPE_VAR);

  logic                   cmd, wait_eff, rd_acc, wr_acc, changed, start;
  logic                   prev_read_q, prev_write_q, prev_held_q;
  logic [NBADDRBITS-1:0]  prev_addr_q;
  logic [NBDATABYTES-1:0] prev_be_q;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic                   hold_err;
  logic [StallW-1:0]      stall_q, stall_d;
  logic                   timeout_hit;
  logic [SumW-1:0]        pend_sum;
  logic [PendW-1:0]       pending_d;
  logic                   pend_ovf;
  wburst_state_t          state_q, state_d;
  logic [7:0]             burst_left_d;
  logic                   burst_abort;
  logic                   lat_tap;
  logic [7:0]             err_d;

  assign cmd      = read | write;
  assign wait_eff = WaitHonoured & waitrequest;
  assign rd_acc   = read & ~wait_eff;
  assign wr_acc   = write & ~wait_eff;
  assign changed  = (read != prev_read_q) || (write != prev_write_q) ||
                    (address != prev_addr_q) || (byteenable != prev_be_q);
  assign start    = wr_acc && beginbursttransfer && (burstcount > 8'd1);

  avalon_chk_latency_pipe #(
    .DEPTH(FIXEDREADLAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .shift_in(IsPipeFixed & rd_acc),
    .tap     (lat_tap)
  );

  // Fixed-wait hold counter: counts cycles the current command has been held.
  always_comb begin
    hold_d   = '0;
    hold_err = 1'b0;
    if (IsFixedWait) begin
      if (hold_q == '0) begin
        if (cmd && FIXEDWAIT > 1) hold_d = HoldW'(1);
      end else if (!cmd || changed) begin
        hold_err = 1'b1;
        // A changed command restarts its own hold window.
        if (cmd && FIXEDWAIT > 1) hold_d = HoldW'(1);
      end else if (hold_q != HoldW'(FIXEDWAIT - 1)) begin
        hold_d = hold_q + HoldW'(1);
      end
    end
  end

  // Stall counter: saturates at TIMEOUT, pulses once on reaching it.
  always_comb begin
    stall_d     = '0;
    timeout_hit = 1'b0;
    if (cmd && wait_eff) begin
      stall_d = stall_q;
      if (stall_q != StallW'(TIMEOUT)) begin
        stall_d     = stall_q + StallW'(1);
        timeout_hit = (stall_q == StallW'(TIMEOUT - 1));
      end
    end
  end

  // Outstanding read beats: add on read accept, retire on readdatavalid, saturate.
  always_comb begin
    pend_sum = SumW'(pending);
    if (rd_acc) pend_sum = pend_sum + (IsBurst ? SumW'(burstcount) : SumW'(1));
    if (readdatavalid && pending != '0) pend_sum = pend_sum - SumW'(1);
    pend_ovf  = pend_sum > SumW'(PendMax);
    pending_d = pend_ovf ? PendW'(PendMax) : pend_sum[PendW-1:0];
    if (!TracksPend) begin
      pending_d = '0;
      pend_ovf  = 1'b0;
    end
  end

  // Write-burst FSM: abort first, then allow a new burst to start in the same cycle.
  always_comb begin
    state_d      = state_q;
    burst_left_d = burst_left;
    burst_abort  = 1'b0;
    if (IsBurst) begin
      if (state_q == WBURST) begin
        if (read || beginbursttransfer) begin
          burst_abort  = 1'b1;
          state_d      = IDLE;
          burst_left_d = '0;
        end else if (wr_acc) begin
          burst_left_d = burst_left - 8'd1;
          if (burst_left == 8'd1) state_d = IDLE;
        end
      end
      if (start && state_d == IDLE) begin
        state_d      = WBURST;
        burst_left_d = burstcount - 8'd1;
      end
    end
  end

  // Violation vector for this cycle.
  always_comb begin
    err_d                   = '0;
    err_d[ERR_RW_CONFLICT]  = read & write;
    err_d[ERR_UNSTABLE]     = IsFixedWait ? hold_err
                                          : (WaitHonoured && prev_held_q && changed);
    err_d[ERR_SPURIOUS_RDV] = TracksPend && readdatavalid && (pending == '0);
    err_d[ERR_PENDING_OVF]  = pend_ovf;
    err_d[ERR_LATENCY]      = IsPipeFixed && (readdatavalid != lat_tap);
    err_d[ERR_BURST_LEN]    = IsBurst && beginbursttransfer &&
                              (burstcount == 8'd0 || 32'(burstcount) > MAXBURST);
    err_d[ERR_BURST_ABORT]  = burst_abort;
    err_d[ERR_TIMEOUT]      = timeout_hit;
  end

  // State registers and registered outputs; a pulse in the clear cycle survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_read_q  <= 1'b0;
      prev_write_q <= 1'b0;
      prev_held_q  <= 1'b0;
      prev_addr_q  <= '0;
      prev_be_q    <= '0;
      hold_q       <= '0;
      stall_q      <= '0;
      state_q      <= IDLE;
      burst_left   <= '0;
      pending      <= '0;
      err_pulse    <= '0;
      err_sticky   <= '0;
    end else begin
      prev_read_q  <= read;
      prev_write_q <= write;
      prev_held_q  <= cmd & wait_eff;
      prev_addr_q  <= address;
      prev_be_q    <= byteenable;
      hold_q       <= hold_d;
      stall_q      <= stall_d;
      state_q      <= state_d;
      burst_left   <= burst_left_d;
      pending      <= pending_d;
      err_pulse    <= err_d;
      err_sticky   <= (clr_err ? 8'h00 : err_sticky) | err_d;
    end
  end

`ifdef AVALON_CHK_STATS_EN
  // Traffic counters, wrapping, cleared by reset or clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      rdv_cnt <= '0;
    end else if (clr_err) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      rdv_cnt <= '0;
    end else begin
      rd_cnt  <= rd_cnt + 32'(rd_acc);
      wr_cnt  <= wr_cnt + 32'(wr_acc);
      rdv_cnt <= rdv_cnt + 32'(readdatavalid);
    end
  end
`endif

endmodule

// File: tb/tb_avalon_mm_checker.sv
// Bench for avalon_mm_checker: one instance per bus mode shares the stimulus;
// each directed step checks the instance it targets, and a randomized phase
// checks the pipelined-variable instance against a counting model.
module tb_avalon_mm_checker;

  localparam int Cap2 = 4;  // MAXPENDING*MAXBURST of the mode-2 instance
  localparam int To2  = 4;  // TIMEOUT of the mode-2 instance

  logic       clk, rst;
  logic [7:0] address, burstcount;
  logic [1:0] byteenable;
  logic       read, write, waitrequest, readdatavalid, beginbursttransfer, clr_err;

  logic [7:0] ep0, es0, ep1, es1, ep2, es2, ep3, es3, ep4, es4;
  logic [7:0] pend0, pend1, pend3, pend4;
  logic [2:0] pend2;
  logic [7:0] bl0, bl1, bl2, bl3, bl4;
`ifdef AVALON_CHK_STATS_EN
  logic [31:0] st_rd [5];
  logic [31:0] st_wr [5];
  logic [31:0] st_rdv[5];
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Model state for the randomized phase.
  int         m_pend, m_stall, m_nxt;
  logic [7:0] m_sticky, m_e, p_addr;
  logic [1:0] p_be;
  logic       p_held, p_rd, p_wr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  avalon_mm_checker #(.AVALONMODE(0), .TIMEOUT(5)) u_m0 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .read(read),
    .write(write), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer), .clr_err(clr_err),
    .err_pulse(ep0), .err_sticky(es0), .pending(pend0),
`ifdef AVALON_CHK_STATS_EN
    .rd_cnt(st_rd[0]), .wr_cnt(st_wr[0]), .rdv_cnt(st_rdv[0]),
`endif
    .burst_left(bl0));

  avalon_mm_checker #(.AVALONMODE(1), .FIXEDWAIT(3)) u_m1 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .read(read),
    .write(write), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer), .clr_err(clr_err),
    .err_pulse(ep1), .err_sticky(es1), .pending(pend1),
`ifdef AVALON_CHK_STATS_EN
    .rd_cnt(st_rd[1]), .wr_cnt(st_wr[1]), .rdv_cnt(st_rdv[1]),
`endif
    .burst_left(bl1));

  avalon_mm_checker #(.AVALONMODE(2), .MAXPENDING(4), .MAXBURST(1), .TIMEOUT(To2)) u_m2 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .read(read),
    .write(write), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer), .clr_err(clr_err),
    .err_pulse(ep2), .err_sticky(es2), .pending(pend2),
`ifdef AVALON_CHK_STATS_EN
    .rd_cnt(st_rd[2]), .wr_cnt(st_wr[2]), .rdv_cnt(st_rdv[2]),
`endif
    .burst_left(bl2));

  avalon_mm_checker #(.AVALONMODE(3), .FIXEDREADLAT(2)) u_m3 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .read(read),
    .write(write), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer), .clr_err(clr_err),
    .err_pulse(ep3), .err_sticky(es3), .pending(pend3),
`ifdef AVALON_CHK_STATS_EN
    .rd_cnt(st_rd[3]), .wr_cnt(st_wr[3]), .rdv_cnt(st_rdv[3]),
`endif
    .burst_left(bl3));

  avalon_mm_checker #(.AVALONMODE(4)) u_m4 (
    .clk(clk), .rst(rst), .address(address), .byteenable(byteenable), .read(read),
    .write(write), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .burstcount(burstcount), .beginbursttransfer(beginbursttransfer), .clr_err(clr_err),
    .err_pulse(ep4), .err_sticky(es4), .pending(pend4),
`ifdef AVALON_CHK_STATS_EN
    .rd_cnt(st_rd[4]), .wr_cnt(st_wr[4]), .rdv_cnt(st_rdv[4]),
`endif
    .burst_left(bl4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    address = 8'h00; byteenable = 2'b00; read = 1'b0; write = 1'b0;
    waitrequest = 1'b0; readdatavalid = 1'b0; burstcount = 8'd0;
    beginbursttransfer = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  initial begin
    int exp_p[7];
    exp_p = '{1, 2, 3, 2, 1, 0, 0};

    // Power-on reset with the clock running.
    idle();
    rst = 1'b0;
    #22;
    check("reset_ep0", ep0, 0);
    check("reset_es1", es1, 0);
    check("reset_pend2", pend2, 0);
    check("reset_ep3", ep3, 0);
    check("reset_bl4", bl4, 0);
    check("reset_pend4", pend4, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Mode 0: command held under waitrequest, address changes on the second cycle.
    read = 1'b1; waitrequest = 1'b1; address = 8'd10;
    tick(); check("m0_hold_c1", ep0, 8'h00);
    address = 8'd11;
    tick(); check("m0_unstable", ep0, 8'h02);
    tick(); check("m0_hold_c3", ep0, 8'h00);
    check("m0_sticky", es0, 8'h02);
    waitrequest = 1'b0;
    tick(); check("m0_accept", ep0, 8'h00);
    read = 1'b0;
    tick();
    // Mode 0: stall timeout after 5 stalled cycles, single pulse.
    read = 1'b1; waitrequest = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("m0_timeout", ep0, (i == 5) ? 8'h80 : 8'h00);
    end
    check("m0_timeout_sticky", es0, 8'h82);

    // Mode 1 (FIXEDWAIT=3): full hold is clean, early drop is flagged.
    do_reset();
    read = 1'b1; address = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick(); check("m1_full_hold", ep1, 8'h00);
    end
    read = 1'b0;
    tick(); check("m1_after_hold", ep1, 8'h00);
    read = 1'b1;
    tick(); check("m1_start", ep1, 8'h00);
    read = 1'b0;
    tick(); check("m1_early_drop", ep1, 8'h02);

    // Mode 2: three read accepts then four beats; the fourth is spurious.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      read = (i < 3);
      readdatavalid = (i >= 3);
      tick();
      check("m2_pending_seq", pend2, exp_p[i]);
      check("m2_rdv_err", ep2, (i == 6) ? 8'h04 : 8'h00);
    end

    // Mode 3 (FIXEDREADLAT=2): late beat gives two latency pulses.
    do_reset();
    read = 1'b1; waitrequest = 1'b1;  // waitrequest is ignored in this mode
    tick(); check("m3_pend_acc", pend3, 1);
    read = 1'b0; waitrequest = 1'b0;
    tick(); check("m3_t1", ep3, 8'h00);
    tick(); check("m3_t2_missing", ep3, 8'h10);
    readdatavalid = 1'b1;
    tick(); check("m3_t3_late", ep3, 8'h10);
    check("m3_pend_ret", pend3, 0);
    readdatavalid = 1'b0;
    tick(); check("m3_quiet", ep3, 8'h00);
    check("m3_sticky", es3, 8'h10);
    // On-time beat is clean.
    read = 1'b1;
    tick(); check("m3_ok_t0", ep3, 8'h00);
    read = 1'b0;
    tick(); check("m3_ok_t1", ep3, 8'h00);
    readdatavalid = 1'b1;
    tick(); check("m3_ok_t2", ep3, 8'h00);
    readdatavalid = 1'b0;

    // Mode 4: burst of 4, two writes, then a read aborts it.
    do_reset();
    write = 1'b1; beginbursttransfer = 1'b1; burstcount = 8'd4;
    tick(); check("m4_bl3", bl4, 3);
    beginbursttransfer = 1'b0;
    tick(); check("m4_bl2", bl4, 2);
    tick(); check("m4_bl1", bl4, 1);
    write = 1'b0; read = 1'b1; burstcount = 8'd1;
    tick(); check("m4_abort", ep4, 8'h40);
    check("m4_abort_bl", bl4, 0);
    check("m4_read_pend", pend4, 1);
    read = 1'b0;
    // Burst length limits.
    beginbursttransfer = 1'b1; burstcount = 8'd0;
    tick(); check("m4_len0", ep4, 8'h20);
    burstcount = 8'd20;
    tick(); check("m4_len20", ep4, 8'h20);
    burstcount = 8'd16;
    tick(); check("m4_len16", ep4, 8'h00);
    beginbursttransfer = 1'b0;
    // Pulse in the same cycle as clr_err stays sticky.
    read = 1'b1; write = 1'b1; clr_err = 1'b1;
    tick(); check("clr_pulse", ep4, 8'h01);
    check("clr_wins", es4, 8'h01);
    read = 1'b0; write = 1'b0;
    tick(); check("clr_only", es4, 8'h00);
    clr_err = 1'b0;
    // Burst of 2 completes normally.
    write = 1'b1; beginbursttransfer = 1'b1; burstcount = 8'd2;
    tick(); check("m4_b2_bl1", bl4, 1);
    beginbursttransfer = 1'b0;
    tick(); check("m4_b2_done", bl4, 0);
    write = 1'b0;
    tick(); check("m4_b2_clean", ep4, 8'h00);
    // Reset in the middle of a burst.
    write = 1'b1; beginbursttransfer = 1'b1; burstcount = 8'd8;
    tick(); check("m4_b8_bl7", bl4, 7);
    read = 1'b1; beginbursttransfer = 1'b0;
    rst = 1'b0;
    #2;
    check("midrst_bl", bl4, 0);
    check("midrst_pend", pend4, 0);
    check("midrst_ep", ep4, 0);
    check("midrst_es", es4, 0);
    idle();
    rst = 1'b1;
    tick(); check("midrst_after", ep4, 8'h00);

    // Randomized mode-2 traffic against a counting model.
    do_reset();
    m_pend = 0; m_stall = 0; m_sticky = 8'h00;
    p_held = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_addr = 8'h00; p_be = 2'b00;
    for (int i = 0; i < 300; i++) begin
      read          = 1'($urandom_range(0, 1));
      write         = ($urandom_range(0, 4) == 0);
      waitrequest   = 1'($urandom_range(0, 1));
      readdatavalid = ($urandom_range(0, 2) == 0);
      address       = 8'($urandom_range(0, 3));
      byteenable    = 2'($urandom_range(0, 3));
      clr_err       = ($urandom_range(0, 7) == 0);
      m_e    = 8'h00;
      m_e[0] = read && write;
      m_e[1] = p_held && (read != p_rd || write != p_wr || address != p_addr ||
                          byteenable != p_be);
      m_e[2] = readdatavalid && (m_pend == 0);
      m_nxt  = m_pend + ((read && !waitrequest) ? 1 : 0)
                      - ((readdatavalid && m_pend > 0) ? 1 : 0);
      if (m_nxt > Cap2) begin
        m_e[3] = 1'b1;
        m_nxt  = Cap2;
      end
      if ((read || write) && waitrequest) begin
        if (m_stall < To2) begin
          m_stall++;
          m_e[7] = (m_stall == To2);
        end
      end else begin
        m_stall = 0;
      end
      m_sticky = (clr_err ? 8'h00 : m_sticky) | m_e;
      p_held = (read || write) && waitrequest;
      p_rd = read; p_wr = write; p_addr = address; p_be = byteenable;
      tick();
      m_pend = m_nxt;
      check("m2_rand_pulse", ep2, m_e);
      check("m2_rand_pend", pend2, m_pend);
      check("m2_rand_sticky", es2, m_sticky);
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
